// File: rtl/control_unit.sv
// control_unit -- sequencing control for the 8-bit processor.
//
// Fetches opcode/immediate bytes over a req/ack instruction port, decodes
// them and, for one EXEC cycle per instruction, drives the ALU operation,
// accumulator write enable and illegal-opcode pulse. It owns the program
// counter and zero flag and resolves JMP/JZ/JNZ.
//
// Build option:
//   CU_JNZ_EN  defined   -> opcode 8 is JNZ (2-byte)
//              undefined -> opcode 8 is a 1-byte illegal opcode
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   fetch request and address (address is the PC)
//   imem_ack/data   memory acknowledge, byte valid in the ack cycle
//   alu_op/alu_imm  ALU operation select (111 = idle) and b operand
//   alu_zero        ALU zero output, captured at the end of an ALU EXEC
//   acc_we          accumulator write strobe (EXEC of ALU ops)
//   zero_flag       registered zero flag
//   halted          high once HLT has been decoded, until reset
//   illegal         one-cycle pulse during EXEC of an undefined opcode
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [2:0] alu_op,
  output logic [7:0] alu_imm,
  input  logic       alu_zero,
  output logic       acc_we,
  output logic       zero_flag,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    EXEC      = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam logic [2:0] ALU_IDLE = 3'b111;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;

  // Opcodes that are followed by an immediate byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: is_two_byte = 1'b1;
`ifdef CU_JNZ_EN
      4'h8:                                     is_two_byte = 1'b1;
`endif
      default:                                  is_two_byte = 1'b0;
    endcase
  endfunction

  // ALU operation for an opcode; ALU_IDLE for everything that is not an ALU op.
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h1:    alu_code = 3'b000;
      4'h2:    alu_code = 3'b001;
      4'h3:    alu_code = 3'b010;
      4'h4:    alu_code = 3'b011;
      4'h5:    alu_code = 3'b100;
      default: alu_code = ALU_IDLE;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF: is_illegal = 1'b0;
`ifdef CU_JNZ_EN
      4'h8:    is_illegal = 1'b0;
`endif
      default: is_illegal = 1'b1;
    endcase
  endfunction

  // The instruction entering EXEC comes straight off the bus for 1-byte
  // opcodes and from the IR when the immediate has just been fetched.
  logic [3:0] exec_op;
  logic [2:0] alu_op_next;
  logic       illegal_next;
  logic       halt_next;

  always_comb begin
    exec_op      = (state == FETCH_OP) ? imem_data[7:4] : ir[7:4];
    alu_op_next  = alu_code(exec_op);
    illegal_next = is_illegal(exec_op);
    halt_next    = (exec_op == 4'hF);
  end

  // Request is combinationally masked by rst so no fetch is ever presented
  // while reset is held, whatever state the register currently holds.
  assign imem_req  = !rst && ((state == FETCH_OP) || (state == FETCH_IMM));
  assign imem_addr = pc;

  // The operand nibble of the opcode byte carries no meaning.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_OP;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      alu_imm   <= 8'h00;
      zero_flag <= 1'b1;
      halted    <= 1'b0;
      acc_we    <= 1'b0;
      illegal   <= 1'b0;
      alu_op    <= ALU_IDLE;
    end else begin
      case (state)
        FETCH_OP: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + 8'd1;
            if (is_two_byte(imem_data[7:4])) begin
              state <= FETCH_IMM;
            end else begin
              // EXEC outputs are registered on the way in so they are
              // valid for the whole EXEC cycle.
              state   <= EXEC;
              alu_op  <= alu_op_next;
              acc_we  <= (alu_op_next != ALU_IDLE);
              illegal <= illegal_next;
              halted  <= halt_next;
            end
          end
        end

        FETCH_IMM: begin
          if (imem_ack) begin
            alu_imm <= imem_data;
            pc      <= pc + 8'd1;
            state   <= EXEC;
            alu_op  <= alu_op_next;
            acc_we  <= (alu_op_next != ALU_IDLE);
            illegal <= illegal_next;
            halted  <= halt_next;
          end
        end

        EXEC: begin
          alu_op  <= ALU_IDLE;
          acc_we  <= 1'b0;
          illegal <= 1'b0;
          // acc_we is high in EXEC exactly for ALU instructions.
          if (acc_we) begin
            zero_flag <= alu_zero;
          end
          // Branch conditions use the flag as it stood before this EXEC.
          case (ir[7:4])
            4'h6: pc <= alu_imm;
            4'h7: if (zero_flag) pc <= alu_imm;
`ifdef CU_JNZ_EN
            4'h8: if (!zero_flag) pc <= alu_imm;
`endif
            default: ;
          endcase
          state <= (ir[7:4] == 4'hF) ? HALT : FETCH_OP;
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= FETCH_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] alu_op;
  logic [7:0] alu_imm;
  logic       alu_zero;
  logic       acc_we;
  logic       zero_flag;
  logic       halted;
  logic       illegal;

  control_unit #(.RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_op    (alu_op),
    .alu_imm   (alu_imm),
    .alu_zero  (alu_zero),
    .acc_we    (acc_we),
    .zero_flag (zero_flag),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // ---------------- memory model with programmable wait states ----------
  logic [7:0] mem [256];
  int         waits = 0;
  int         wait_cnt;
  logic       force_ack = 1'b0;

  assign imem_data = mem[imem_addr];
  assign imem_ack  = force_ack | (imem_req & (wait_cnt >= waits));

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  // ---------------- accumulator / ALU model -----------------------------
  logic [7:0] acc;
  logic [7:0] alu_res;
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = acc + alu_imm;
      3'b001:  alu_res = acc - alu_imm;
      3'b010:  alu_res = acc & alu_imm;
      3'b011:  alu_res = acc | alu_imm;
      3'b100:  alu_res = alu_imm;
      default: alu_res = 8'h00;
    endcase
  end
  assign alu_zero = (alu_res == 8'h00);

  always @(posedge clk) begin
    if (rst)         acc <= 8'h00;
    else if (acc_we) acc <= alu_res;
  end

  // ---------------- checking ---------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [2:0] op, input logic [7:0] imm, input int c);
    exp_t e;
    e.op = op; e.imm = imm; e.cyc = c;
    sb.push_back(e);
  endtask

  int         cyc;
  logic       prev_req;
  logic       prev_ack;
  logic [7:0] prev_addr;

  // One clock: sample at the falling edge, pop the scoreboard on acc_we and
  // check handshake stability while a request is outstanding.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      cyc++;
      if (acc_we) begin
        if (sb.size() == 0) begin
          chk("sb_extra_we", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("cyc %0d: acc_we op=%0b imm=%02h", cyc, alu_op, alu_imm);
          chk("we_op",  alu_op,  e.op);
          chk("we_imm", alu_imm, e.imm);
          chk("we_cyc", cyc,     e.cyc);
        end
      end
      if (prev_req && !prev_ack) begin
        chk("hold_req",  imem_req,  1'b1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    force_ack = 1'b0;
    cyc       = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 8'h00;
  endtask

  task automatic end_test(input string tag);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h05;
    mem[2] = 8'h10; mem[3] = 8'h03;
    mem[4] = 8'hF0;
  endtask

  initial begin
    clear_mem();
    cyc = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;

    // ---- reset values, ack during reset ignored ----
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",     imem_req,  1'b0);
    chk("rst_alu_op",  alu_op,    3'b111);
    chk("rst_acc_we",  acc_we,    1'b0);
    chk("rst_zero",    zero_flag, 1'b1);
    chk("rst_halted",  halted,    1'b0);
    chk("rst_illegal", illegal,   1'b0);
    chk("rst_imm",     alu_imm,   8'h00);

    // ---- LDI 05, ADD 03, HLT, zero wait ----
    load_prog_a();
    waits = 0;
    do_reset();
    push(3'b100, 8'h05, 3);
    push(3'b000, 8'h03, 6);
    tick();
    chk("a_first_req",  imem_req,  1'b1);
    chk("a_first_addr", imem_addr, 8'h00);
    run_to(7);
    chk("a_c7_halted", halted, 1'b0);
    run_to(8);
    chk("a_c8_halted", halted,    1'b1);
    chk("a_c8_addr",   imem_addr, 8'h05);
    run_to(12);
    chk("a_halt_hold", halted,    1'b1);
    chk("a_halt_req",  imem_req,  1'b0);
    chk("a_zero",      zero_flag, 1'b0);
    end_test("a");

    // ---- same program with 3 wait cycles per fetch ----
    waits = 3;
    do_reset();
    push(3'b100, 8'h05, 9);
    push(3'b000, 8'h03, 18);
    run_to(22);
    chk("w_c22_halted", halted, 1'b0);
    run_to(23);
    chk("w_c23_halted", halted,    1'b1);
    chk("w_c23_addr",   imem_addr, 8'h05);
    end_test("w");
    waits = 0;

    // ---- LDI 00, JZ 40: taken ----
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h00;
    mem[2] = 8'h70; mem[3] = 8'h40;
    do_reset();
    push(3'b100, 8'h00, 3);
    run_to(7);
    chk("jz_t_addr", imem_addr, 8'h40);
    chk("jz_t_zero", zero_flag, 1'b1);
    end_test("jz_t");

    // ---- LDI 01, JZ 40: not taken ----
    mem[1] = 8'h01;
    do_reset();
    push(3'b100, 8'h01, 3);
    run_to(7);
    chk("jz_n_addr", imem_addr, 8'h04);
    chk("jz_n_zero", zero_flag, 1'b0);
    end_test("jz_n");

    // ---- PC wrap: JMP FF, NOP at FF ----
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'hFF;
    mem[255] = 8'h00;
    do_reset();
    run_to(4);
    chk("wrap_ff",  imem_addr, 8'hFF);
    run_to(6);
    chk("wrap_00",  imem_addr, 8'h00);
    chk("wrap_req", imem_req,  1'b1);
    end_test("wrap");

    // ---- illegal opcode A0 ----
    clear_mem();
    mem[0] = 8'hA0;
    mem[1] = 8'h50; mem[2] = 8'h07;
    do_reset();
    push(3'b100, 8'h07, 5);
    run_to(2);
    chk("ill_pulse",  illegal, 1'b1);
    chk("ill_no_we",  acc_we,  1'b0);
    run_to(3);
    chk("ill_clear",  illegal,   1'b0);
    chk("ill_addr",   imem_addr, 8'h01);
    run_to(6);
    end_test("ill");

    // ---- opcode 8 ----
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h01;
    mem[2] = 8'h80; mem[3] = 8'h10;
    do_reset();
    push(3'b100, 8'h01, 3);
`ifdef CU_JNZ_EN
    run_to(5);
    chk("jnz_c5_ill", illegal,  1'b0);
    chk("jnz_c5_req", imem_req, 1'b1);
    run_to(7);
    chk("jnz_taken",  imem_addr, 8'h10);
`else
    push(3'b000, 8'hF0, 8);
    run_to(5);
    chk("op8_ill",   illegal,  1'b1);
    chk("op8_req",   imem_req, 1'b0);
    run_to(6);
    chk("op8_addr",  imem_addr, 8'h03);
    chk("op8_clear", illegal,   1'b0);
`endif
    run_to(9);
    end_test("op8");

    // ---- reset during FETCH_IMM with ack high ----
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h01;
    mem[2] = 8'h50; mem[3] = 8'hAA;
    do_reset();
    push(3'b100, 8'h01, 3);
    run_to(5);
    chk("mid_fi_req",  imem_req,  1'b1);
    chk("mid_fi_ack",  imem_ack,  1'b1);
    chk("mid_fi_zero", zero_flag, 1'b0);
    end_test("mid_pre");
    rst       = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_imm", alu_imm,  8'h00);
    do_reset();
    push(3'b100, 8'h01, 3);
    tick();
    chk("mid_rel_req",  imem_req,  1'b1);
    chk("mid_rel_addr", imem_addr, 8'h00);
    chk("mid_rel_zero", zero_flag, 1'b1);
    chk("mid_rel_imm",  alu_imm,   8'h00);
    run_to(4);
    end_test("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
